uart_receiver: RTL and testbench
================================

# uart_receiver

Asynchronous serial receiver that pairs with the team's UART transmitter. It recovers 8N1 frames from the serial line and presents each byte with a ready/clear handshake. It also reports framing and overrun errors. It sits between the board RX pin (or a transmitter's TX output in loopback) and the byte consumer (LED register, command parser).

## Interface
Parameters:
- BAUD_DIV, 2604: clock cycles per bit (50 MHz / 19200 baud); legal range ≥ 8.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- RX  in  1  serial line, idles high, asynchronous to clk.
- rx_rdy_clr  in  1  consumer acknowledge, single-cycle pulse.
- rx_data  out  8  last good byte received.
- rx_rdy  out  1  a good byte is waiting in rx_data.
- frm_err  out  1  sticky: a stop bit was sampled low.
- ovr_err  out  1  sticky: a byte completed while rx_rdy was already 1.

## Operation
- RX passes through a 2-flop synchronizer; both flops reset to 1. Edge detection uses one more flop, also reset to 1.
- States:
  - IDLE: on a synchronized falling edge, load the baud counter for a half bit and go to START.
  - START: on expiry, if the sample is 1 (false start), return to IDLE. Otherwise load a full bit, clear bit_cnt, go to DATA.
  - DATA: on each expiry, shift the sample in LSB-first (shift right, new bit into bit 7) and increment bit_cnt. After the 8th bit, go to STOP.
  - STOP: on expiry, if the sample is 1, load rx_data from the shift register and set rx_rdy. If the sample is 0, set frm_err and leave rx_data and rx_rdy unchanged. Go to IDLE in either case.
- After a framing error the line may stay low (break). IDLE waits for a high-then-low transition before starting a new frame.
- rx_rdy_clr clears rx_rdy, frm_err and ovr_err.
- Overrun: a good stop while rx_rdy=1 sets ovr_err. rx_data is overwritten with the new byte.
- Simultaneous events:
  - Good stop and rx_rdy_clr in the same cycle: rx_rdy stays 1, rx_data is updated, ovr_err is not set.
  - Error set and rx_rdy_clr in the same cycle: the error set wins.
- Reset mid-frame: every register returns to its reset value immediately and the FSM goes to IDLE. The partial frame is discarded.
- The baud counter is a down-counter of width $clog2(BAUD_DIV). It expires when it reaches 0.
  - Half-bit load: BAUD_DIV/2 − 1 (integer division).
  - Full-bit load: BAUD_DIV − 1.

## Timing
- Reset values: rx_data=8'h00, rx_rdy=0, frm_err=0, ovr_err=0, FSM=IDLE.
- Let t0 be the cycle in which the falling edge is detected, 2 cycles after the pin transition. Sample k (k=0 start, 1–8 data, 9 stop) is taken at t0 + BAUD_DIV/2 + k·BAUD_DIV.
- rx_rdy and rx_data update on the clock edge after sample 9.
- The FSM is in IDLE at that same edge. Back-to-back frames with no idle gap are received.
- rx_rdy_clr takes effect on the next rising edge.

## Configuration
- UART_RX_MAJORITY_EN defined:
  - A 3-bit history of the synchronized RX is kept.
  - Each bit value is the 2-of-3 majority of the samples at expiry−2, expiry−1 and expiry.
  - The start-bit check uses the same vote.
- Undefined:
  - Each bit value is the single synchronized sample at expiry.
  - No history register is built.

## Structure
- Package uart_pkg holds:
  - the FSM state typedef (IDLE, START, DATA, STOP);
  - UART_DEFAULT_BAUD_DIV = 2604;
  - UART_DATA_BITS = 8.
- Sub-module uart_rx_baud_cnt holds the down-counter with load_half, load_full and expire outputs. The FSM, shift register and flags stay in uart_receiver.

## Test plan
All scenarios run with BAUD_DIV=16.
- Good frame: drive 0x1D as 8N1 → rx_data=0x1D and rx_rdy=1 exactly at t0+152; frm_err=0 and ovr_err=0. Pulse rx_rdy_clr → rx_rdy=0 the next cycle.
- Overrun: send 0x7D then 0xA5 back-to-back without clearing → rx_data=0xA5, rx_rdy=1, ovr_err=1. A following rx_rdy_clr → all three flags 0.
- Framing error: send 0x3C with the stop bit driven 0 → frm_err=1, rx_rdy=0, rx_data keeps its prior value. The line then returns high and 0x55 is sent → rx_data=0x55.
- False start: a 4-cycle low pulse on RX (shorter than half a bit, 8 cycles) → FSM back in IDLE, rx_rdy stays 0, no error flags.
- Reset mid-frame: assert rst during data bit 4 of 0xF0 → outputs 0 and FSM in IDLE immediately. Deassert rst and send 0x81 → rx_data=0x81.
- Majority vote (macro defined): send 0x00 with a 1-cycle high glitch at the expiry cycle of bit 3 → rx_data=0x00. With the macro undefined, the same stimulus → rx_data=0x08.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: frame geometry, default baud
// divider, receiver FSM states and the 2-of-3 vote used when the optional
// majority sampler (UART_RX_MAJORITY_EN) is built.
package uart_pkg;

    // 50 MHz system clock / 19200 baud
    localparam int UART_DEFAULT_BAUD_DIV = 2604;

    // 8N1 framing: eight data bits, LSB first
    localparam int UART_DATA_BITS = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    // 2-of-3 majority of three line samples
    function automatic logic majority3(input logic [2:0] samples);
        return (samples[0] & samples[1]) |
               (samples[0] & samples[2]) |
               (samples[1] & samples[2]);
    endfunction

endpackage

// File: rtl/uart_rx_baud_cnt.sv
// Bit-timing down-counter for the UART receiver. The FSM loads either a
// half-bit count (to land in the middle of the start bit) or a full-bit
// count (to step from one bit centre to the next). The counter then runs
// down and parks at zero; expire is high whenever it sits at zero, and the
// FSM only pays attention to it outside IDLE.
module uart_rx_baud_cnt
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = UART_DEFAULT_BAUD_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic load_half,
    input  logic load_full,
    output logic expire
);

    localparam int CNT_W = $clog2(BAUD_DIV);
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(BAUD_DIV / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(BAUD_DIV - 1);

    logic [CNT_W-1:0] cnt;

    // Load on request, otherwise count down and hold at zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load_full) begin
            cnt <= FULL_LOAD;
        end else if (load_half) begin
            cnt <= HALF_LOAD;
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign expire = (cnt == '0);

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver with ready/clear handshake and sticky framing/overrun
// flags. RX is synchronised through two flops, a falling edge on the
// synchronised line starts a frame, and each bit is sampled at its centre.
// Optional feature: define UART_RX_MAJORITY_EN to take every bit (and the
// start-bit check) as the 2-of-3 vote of the last three synchronised samples
// instead of the single sample at the bit centre.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = UART_DEFAULT_BAUD_DIV
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      RX,
    input  logic                      rx_rdy_clr,
    output logic [UART_DATA_BITS-1:0] rx_data,
    output logic                      rx_rdy,
    output logic                      frm_err,
    output logic                      ovr_err
);

    localparam int BIT_CNT_W = $clog2(UART_DATA_BITS);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(UART_DATA_BITS - 1);

    rx_state_t state;
    rx_state_t next_state;

    logic rx_meta;
    logic rx_sync;
    logic rx_prev;
    logic fall_det;
    logic bit_val;

    logic load_half;
    logic load_full;
    logic expire;
    logic shift_en;
    logic cnt_clr;
    logic stop_good;
    logic stop_bad;

    logic [BIT_CNT_W-1:0]      bit_cnt;
    logic [UART_DATA_BITS-1:0] shift_reg;

    // Two-flop synchroniser plus one delay flop for edge detection; all idle
    // high so reset never looks like a start edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= RX;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    // Needs the line high then low, so a held-low break cannot restart a frame
    assign fall_det = rx_prev & ~rx_sync;

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] rx_hist;

    // Keep the two previous synchronised samples; with the live sample they
    // form the three-sample voting window ending at the bit centre
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_hist <= 2'b11;
        end else begin
            rx_hist <= {rx_hist[0], rx_sync};
        end
    end

    assign bit_val = majority3({rx_hist, rx_sync});
`else
    assign bit_val = rx_sync;
`endif

    uart_rx_baud_cnt #(
        .BAUD_DIV (BAUD_DIV)
    ) u_baud_cnt (
        .clk       (clk),
        .rst       (rst),
        .load_half (load_half),
        .load_full (load_full),
        .expire    (expire)
    );

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and per-cycle control strobes
    always_comb begin
        next_state = state;
        load_half  = 1'b0;
        load_full  = 1'b0;
        shift_en   = 1'b0;
        cnt_clr    = 1'b0;
        stop_good  = 1'b0;
        stop_bad   = 1'b0;
        case (state)
            IDLE: begin
                if (fall_det) begin
                    load_half  = 1'b1;
                    next_state = START;
                end
            end
            START: begin
                if (expire) begin
                    if (bit_val) begin
                        next_state = IDLE;
                    end else begin
                        load_full  = 1'b1;
                        cnt_clr    = 1'b1;
                        next_state = DATA;
                    end
                end
            end
            DATA: begin
                if (expire) begin
                    shift_en  = 1'b1;
                    load_full = 1'b1;
                    if (bit_cnt == LAST_BIT) begin
                        next_state = STOP;
                    end
                end
            end
            STOP: begin
                if (expire) begin
                    if (bit_val) begin
                        stop_good = 1'b1;
                    end else begin
                        stop_bad = 1'b1;
                    end
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Data-bit counter, cleared when a valid start bit is confirmed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt <= '0;
        end else if (cnt_clr) begin
            bit_cnt <= '0;
        end else if (shift_en) begin
            bit_cnt <= bit_cnt + BIT_CNT_W'(1);
        end
    end

    // LSB-first shift register: each new bit enters at the top
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_reg <= '0;
        end else if (shift_en) begin
            shift_reg <= {bit_val, shift_reg[UART_DATA_BITS-1:1]};
        end
    end

    // Output byte and status flags; a frame event in the same cycle as an
    // acknowledge takes priority over the clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_data <= '0;
            rx_rdy  <= 1'b0;
            frm_err <= 1'b0;
            ovr_err <= 1'b0;
        end else begin
            if (stop_good) begin
                rx_data <= shift_reg;
                rx_rdy  <= 1'b1;
            end else if (rx_rdy_clr) begin
                rx_rdy <= 1'b0;
            end

            if (stop_bad) begin
                frm_err <= 1'b1;
            end else if (rx_rdy_clr) begin
                frm_err <= 1'b0;
            end

            if (stop_good && rx_rdy && !rx_rdy_clr) begin
                ovr_err <= 1'b1;
            end else if (rx_rdy_clr) begin
                ovr_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver at BAUD_DIV=16: directed scenarios
// followed by randomised frames, checked cycle by cycle against a
// frame-level reference model fed through an event scoreboard.
module tb_uart_receiver;
    import uart_pkg::*;

    localparam int B = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       RX = 1'b1;
    logic       rx_rdy_clr = 1'b0;
    logic [7:0] rx_data;
    logic       rx_rdy;
    logic       frm_err;
    logic       ovr_err;

    uart_receiver #(
        .BAUD_DIV (B)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .RX         (RX),
        .rx_rdy_clr (rx_rdy_clr),
        .rx_data    (rx_data),
        .rx_rdy     (rx_rdy),
        .frm_err    (frm_err),
        .ovr_err    (ovr_err)
    );

    always #5 clk = ~clk;

    int edges = 0;
    always @(posedge clk) edges <= edges + 1;

    typedef enum {EV_GOOD, EV_BAD, EV_CLEAR, EV_RESET} ev_kind_t;
    typedef struct {
        int         due;
        ev_kind_t   kind;
        logic [7:0] data;
    } ev_t;

    ev_t evq[$];

    logic [7:0] m_data = 8'h00;
    logic       m_rdy = 1'b0;
    logic       m_frm = 1'b0;
    logic       m_ovr = 1'b0;

    int checks = 0;
    int failures = 0;

    // Apply every expected event due at the edge just taken: a reset drops
    // everything, acknowledges act before frame completions on the same edge
    task automatic apply_due_events();
        ev_t pending[$];
        ev_t frames[$];
        bit  hit_reset;
        hit_reset = 1'b0;
        foreach (evq[i]) begin
            if (evq[i].kind == EV_RESET && evq[i].due <= edges) hit_reset = 1'b1;
        end
        if (hit_reset) begin
            evq.delete();
            m_data = 8'h00;
            m_rdy  = 1'b0;
            m_frm  = 1'b0;
            m_ovr  = 1'b0;
            return;
        end
        foreach (evq[i]) begin
            if (evq[i].due <= edges) begin
                if (evq[i].kind == EV_CLEAR) begin
                    m_rdy = 1'b0;
                    m_frm = 1'b0;
                    m_ovr = 1'b0;
                end else begin
                    frames.push_back(evq[i]);
                end
            end else begin
                pending.push_back(evq[i]);
            end
        end
        foreach (frames[i]) begin
            if (frames[i].kind == EV_GOOD) begin
                if (m_rdy) m_ovr = 1'b1;
                m_data = frames[i].data;
                m_rdy  = 1'b1;
            end else begin
                m_frm = 1'b1;
            end
        end
        evq = pending;
    endtask

    // Monitor: every falling edge, bring the model up to date and compare
    initial begin
        forever begin
            @(negedge clk);
            apply_due_events();
            checks++;
            if ({rx_data, rx_rdy, frm_err, ovr_err} !== {m_data, m_rdy, m_frm, m_ovr}) begin
                failures++;
                if (failures <= 25)
                    $display("[TB] FAIL outputs edge=%0d got data=%02h rdy=%b frm=%b ovr=%b expected data=%02h rdy=%b frm=%b ovr=%b",
                             edges, rx_data, rx_rdy, frm_err, ovr_err, m_data, m_rdy, m_frm, m_ovr);
            end
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog expired at edge %0d", edges);
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        RX = 1'b1;
        rx_rdy_clr = 1'b0;
        repeat (n) tick();
    endtask

    task automatic hold_low(input int n);
        RX = 1'b0;
        rx_rdy_clr = 1'b0;
        repeat (n) tick();
    endtask

    task automatic pulse_clear();
        ev_t e;
        e.due = edges + 1;
        e.kind = EV_CLEAR;
        e.data = 8'h00;
        evq.push_back(e);
        rx_rdy_clr = 1'b1;
        tick();
        rx_rdy_clr = 1'b0;
    endtask

    task automatic check_state(input string name, input rx_state_t want);
        checks++;
        if (dut.state !== want) begin
            failures++;
            $display("[TB] FAIL %s state got %s expected %s", name, dut.state.name(), want.name());
        end
    endtask

    // Drive one 8N1 frame; glitch_bit inverts one cycle at that bit's centre,
    // clr_at_stop lands an acknowledge on the completion edge
    task automatic send_frame(input logic [7:0] d, input logic stop_bit,
                              input int glitch_bit, input bit clr_at_stop);
        int         a;
        logic [9:0] bits;
        logic [7:0] expect_byte;
        ev_t        e;
        a = edges + 1;
        bits = {stop_bit, d, 1'b0};
        expect_byte = d;
`ifndef UART_RX_MAJORITY_EN
        if (glitch_bit >= 1 && glitch_bit <= 8)
            expect_byte[glitch_bit-1] = ~expect_byte[glitch_bit-1];
`endif
        e.due  = a + 2 + B / 2 + 9 * B;
        e.kind = stop_bit ? EV_GOOD : EV_BAD;
        e.data = expect_byte;
        evq.push_back(e);
        if (clr_at_stop) begin
            e.kind = EV_CLEAR;
            evq.push_back(e);
        end
        for (int k = 0; k < 10; k++) begin
            for (int j = 0; j < B; j++) begin
                RX = bits[k];
                if (k == glitch_bit && j == B / 2) RX = ~bits[k];
                rx_rdy_clr = (clr_at_stop && (edges + 1 == e.due));
                tick();
            end
        end
        rx_rdy_clr = 1'b0;
    endtask

    logic [7:0] rd;
    logic       rs;
    int         rg;
    int         gap;
    bit         rc;
    logic [9:0] pbits;
    ev_t        rev;

    initial begin
        rst = 1'b1;
        RX = 1'b1;
        rx_rdy_clr = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        idle(5);

        // Good frame and acknowledge
        send_frame(8'h1D, 1'b1, -1, 1'b0);
        idle(3);
        pulse_clear();
        idle(3);

        // Overrun from back-to-back frames, then clear
        send_frame(8'h7D, 1'b1, -1, 1'b0);
        send_frame(8'hA5, 1'b1, -1, 1'b0);
        idle(2);
        pulse_clear();
        idle(2);

        // Framing error followed by a break, recovery on a clean frame
        send_frame(8'h3C, 1'b0, -1, 1'b0);
        hold_low(2 * B);
        idle(4);
        send_frame(8'h55, 1'b1, -1, 1'b0);
        idle(2);
        pulse_clear();
        idle(2);

        // False start: short low pulse
        hold_low(4);
        check_state("false_start_entered", START);
        idle(B);
        check_state("false_start_idle", IDLE);

        // Acknowledge coinciding with a good stop, then with a bad stop
        send_frame(8'h12, 1'b1, -1, 1'b0);
        send_frame(8'h34, 1'b1, -1, 1'b1);
        send_frame(8'h56, 1'b0, -1, 1'b1);
        idle(4);
        pulse_clear();
        idle(2);

        // Single-cycle glitch at the centre of data bit 3 of 0x00
        send_frame(8'h00, 1'b1, 4, 1'b0);
        idle(3);

        // Reset in the middle of data bit 4 of 0xF0, then a fresh frame
        pbits = {1'b1, 8'hF0, 1'b0};
        for (int c = 0; c < 5 * B + B / 2; c++) begin
            RX = pbits[c / B];
            tick();
        end
        rst = 1'b1;
        RX = 1'b1;
        rev.due = edges;
        rev.kind = EV_RESET;
        rev.data = 8'h00;
        evq.push_back(rev);
        #1;
        checks++;
        if ({rx_data, rx_rdy, frm_err, ovr_err} !== 11'd0) begin
            failures++;
            $display("[TB] FAIL reset_outputs got data=%02h rdy=%b frm=%b ovr=%b expected all zero",
                     rx_data, rx_rdy, frm_err, ovr_err);
        end
        check_state("reset_idle", IDLE);
        repeat (3) tick();
        rst = 1'b0;
        idle(5);
        send_frame(8'h81, 1'b1, -1, 1'b0);
        idle(3);
        pulse_clear();
        idle(3);

        // Randomised traffic
        for (int n = 0; n < 30; n++) begin
            rd = 8'($urandom_range(0, 255));
            rs = ($urandom_range(0, 7) != 0);
            rg = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 8)) : -1;
            rc = ($urandom_range(0, 5) == 0);
            send_frame(rd, rs, rg, rc);
            gap = rs ? int'($urandom_range(0, 12)) : int'($urandom_range(2, 12));
            for (int g = 0; g < gap; g++) begin
                if ($urandom_range(0, 4) == 0) pulse_clear();
                else idle(1);
            end
        end

        idle(20);
        checks++;
        if (evq.size() != 0) begin
            failures++;
            $display("[TB] FAIL scoreboard_drain got %0d pending expected 0", evq.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
